// File: rtl/nios_button_ctrl.sv
// Avalon-MM pushbutton controller: synchronised, debounced state, W1C press-edge capture, press counter, maskable level IRQ.
// Pin-to-state latency is 2 + DEBOUNCE_CYCLES clocks; readdata and irq are registered (read latency 1).
module nios_button_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    btn_state_t       fsm_q [WIDTH];
    btn_state_t       fsm_d [WIDTH];
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] qualify, state_vec;
    logic [WIDTH-1:0] edge_q, edge_d, mask_q, mask_d;
    logic [15:0]      press_cnt_q, press_cnt_d;
    logic [15:0]      cnt_base;
    logic [5:0]       n_inc;
    logic [16:0]      cnt_sum;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en, rd_en;

    assign wr_en    = chipselect & write;
    assign rd_en    = chipselect & read;
    assign readdata = readdata_q;
    assign irq      = irq_q;

    always_comb begin
        sync1_d = in_port ^ {WIDTH{ACTIVE_LOW}};
        sync2_d = sync1_q;
    end

    // Qualification compares the incremented count so that exactly DEBOUNCE_CYCLES stable samples are required.
    always_comb begin
        qualify   = '0;
        state_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fsm_d[i] = fsm_q[i];
            cnt_d[i] = cnt_q[i];
            case (fsm_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        fsm_d[i] = PRESS_WAIT;
                        cnt_d[i] = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        fsm_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        if (cnt_d[i] == CNT_LAST) begin
                            fsm_d[i]   = PRESSED;
                            qualify[i] = 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!sync2_q[i]) begin
                        fsm_d[i] = RELEASE_WAIT;
                        cnt_d[i] = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        fsm_d[i] = PRESSED;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        if (cnt_d[i] == CNT_LAST) begin
                            fsm_d[i] = IDLE;
                        end
                    end
                end
                default: fsm_d[i] = IDLE;
            endcase
            state_vec[i] = (fsm_q[i] == PRESSED) || (fsm_q[i] == RELEASE_WAIT);
        end
    end

    // A new press always wins over a same-cycle W1C or count clear.
    always_comb begin
        edge_d = edge_q;
        if (wr_en && address == 2'd2) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        edge_d = edge_d | qualify;

        mask_d = mask_q;
        if (wr_en && address == 2'd1) begin
            mask_d = writedata[WIDTH-1:0];
        end

        n_inc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n_inc = n_inc + 6'(qualify[i]);
        end
        cnt_base    = (wr_en && address == 2'd3) ? 16'h0000 : press_cnt_q;
        cnt_sum     = {1'b0, cnt_base} + 17'(n_inc);
        press_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

        readdata_d = '0;
        if (rd_en) begin
            case (address)
                2'd0:    readdata_d[WIDTH-1:0] = state_vec;
                2'd1:    readdata_d[WIDTH-1:0] = mask_q;
                2'd2:    readdata_d[WIDTH-1:0] = edge_q;
                default: readdata_d[15:0]      = press_cnt_q;
            endcase
        end

        irq_d = |(edge_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            edge_q      <= '0;
            mask_q      <= '0;
            press_cnt_q <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                fsm_q[i] <= IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            edge_q      <= edge_d;
            mask_q      <= mask_d;
            press_cnt_q <= press_cnt_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
            for (int i = 0; i < WIDTH; i++) begin
                fsm_q[i] <= fsm_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
